// File: rtl/prbs17_checker.sv
// Receive-side checker for the 16-bit-per-word truncated PRBS17 stream.
// It seeds itself from the incoming words, verifies and locks, counts word errors, and recovers the BCID.
module prbs17_checker #(
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_COUNT = 4,
  parameter int ERRCNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    din_valid,
  input  logic [15:0]             din,
  input  logic                    clear_err,
  output logic                    locked,
  output logic                    err,
  output logic [ERRCNT_WIDTH-1:0] err_count,
  output logic [11:0]             bcid,
  output logic                    bcid_valid
);

  localparam logic [16:0] SEED_STATE = 17'h0AAAA;
  localparam logic [16:0] LAST_STATE = 17'h0A96E;
  localparam logic [11:0] BCID_MAX   = 12'd3563;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_SEED   = 2'd1;
  localparam logic [1:0] ST_VERIFY = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int XW = $clog2(UNLOCK_COUNT + 1);

  // Sixteen serial LFSR steps. Bit 0 is the earliest bit, and each new bit enters at the MSB.
  function automatic logic [15:0] gen_word(input logic [16:0] s);
    logic [16:0] c;
    logic [15:0] w;
    c = s;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      w[i] = c[3] ^ c[0];
      c    = {w[i], c[16:1]};
    end
    return w;
  endfunction

  logic [1:0]    state;
  logic          prev_msb;
  logic [16:0]   e_state;
  logic [MW-1:0] match_cnt;
  logic [XW-1:0] miss_cnt;

  logic [15:0] exp_word;
  logic [16:0] e_next;
  logic        match;
  logic        at_seed;
  logic [11:0] bcid_next;

  always_comb begin
    exp_word  = gen_word(e_state);
    e_next    = (e_state == LAST_STATE) ? SEED_STATE : {exp_word, e_state[16]};
    match     = (din == exp_word);
    at_seed   = (e_state == SEED_STATE);
    bcid_next = (at_seed || bcid == BCID_MAX) ? 12'd0 : bcid + 12'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_SEARCH;
      prev_msb   <= 1'b0;
      e_state    <= '0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_count  <= '0;
      bcid       <= '0;
      bcid_valid <= 1'b0;
    end else begin
      err <= 1'b0;
      if (enable) begin
        if (clear_err) err_count <= '0;
        if (din_valid) begin
          case (state)
            ST_SEARCH: begin
              prev_msb <= din[15];
              state    <= ST_SEED;
            end
            ST_SEED: begin
              // The state that follows a word is {word, previous word's MSB}.
              e_state   <= {din, prev_msb};
              match_cnt <= '0;
              state     <= ST_VERIFY;
            end
            ST_VERIFY: begin
              e_state <= e_next;
              bcid    <= bcid_next;
              if (match) begin
                if (at_seed) bcid_valid <= 1'b1;
                if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                  state    <= ST_LOCKED;
                  locked   <= 1'b1;
                  miss_cnt <= '0;
                end else begin
                  match_cnt <= match_cnt + 1'b1;
                end
              end else begin
                prev_msb   <= din[15];
                bcid_valid <= 1'b0;
                state      <= ST_SEED;
              end
            end
            default: begin
              // Flywheel: the expected state advances even on a miss.
              e_state <= e_next;
              bcid    <= bcid_next;
              if (at_seed) bcid_valid <= 1'b1;
              if (match) begin
                miss_cnt <= '0;
              end else begin
                err <= 1'b1;
                if (!clear_err && err_count != '1) err_count <= err_count + 1'b1;
                if (miss_cnt == XW'(UNLOCK_COUNT - 1)) begin
                  state      <= ST_SEARCH;
                  locked     <= 1'b0;
                  bcid_valid <= 1'b0;
                end else begin
                  miss_cnt <= miss_cnt + 1'b1;
                end
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: doc/prbs17_checker.md
Name: prbs17_checker

Overview:
- Receive-side checker for the 16-bit-per-word PRBS17 test stream from the ETROC2 readout PRBS generator.
- Self-seeds from the incoming words and locks onto the truncated 3564-word sequence.
- Flags and counts word errors, and recovers the BCID aligned to the sequence seed.
- Sits at the far end of the serial link (DAQ/test side), after deserialization and word alignment.

Parameters:
- LOCK_COUNT, 8: consecutive matching words in VERIFY needed to declare lock.
- UNLOCK_COUNT, 4: consecutive mismatching words in LOCKED that drop lock.
- ERRCNT_WIDTH, 16: width of the saturating error counter.

Ports:
- clk  input  1  word clock (40 MHz).
- reset  input  1  synchronous, active-low.
- enable  input  1  0 = freeze all state and outputs except the err pulse, which is cleared.
- din_valid  input  1  din carries a word this cycle.
- din  input  16  received word; bit 0 is the earliest bit (LSB-first order).
- clear_err  input  1  synchronous clear of err_count.
- locked  output  1  checker is in LOCKED.
- err  output  1  one-cycle pulse: the last accepted word mismatched while LOCKED.
- err_count  output  ERRCNT_WIDTH  mismatched words while LOCKED; saturates at all-ones.
- bcid  output  12  BCID of the last accepted word, range 0..3563.
- bcid_valid  output  1  bcid is meaningful.

Behaviour:
- Reset is synchronous and active-low on clk. All outputs are registered. Reset values: locked=0, err=0, err_count=0, bcid=0, bcid_valid=0. The FSM resets to SEARCH.
- Sequence model (17-bit state S):
  - Output word: w[i] = c[i][3] ^ c[i][0], with c[0] = S and c[i+1] = {w[i], c[i][16:1]}, for i = 0..15.
  - Successor: next(S) = 17'h0AAAA if S == 17'h0A96E, else c[16].
  - Seed 17'h0AAAA carries BCID 0. State 17'h0A96E is the last state, BCID 3563. Period is 3564 words.
- Seeding identity: the state after word w(n) is {w(n), w(n-1)[15]}.
- A word is accepted only when enable=1 and din_valid=1. Gaps leave every register unchanged.
- FSM:
  - SEARCH: on an accepted word, store it as prev, go to SEED.
  - SEED: on an accepted word, E = next-expected state = {din, prev[15]}. Clear the match counter. Go to VERIFY.
  - VERIFY: on an accepted word, compare din with the word generated from E, then E <= next(E).
    - Match: increment the match counter. When it reaches LOCK_COUNT, go to LOCKED.
    - Mismatch: store din as prev, go to SEED (re-seed).
    - A seed that lands on the wrap boundary mismatches and re-seeds automatically.
  - LOCKED: on every accepted word, E <= next(E) (flywheel), independent of the compare result.
    - Mismatch: err=1 for one cycle, err_count += 1 (saturating), consecutive-miss counter += 1. When the miss counter reaches UNLOCK_COUNT: locked=0, bcid_valid=0, go to SEARCH.
    - Match: clear the consecutive-miss counter.
- Latency: err, locked, bcid and bcid_valid update on the clock edge that accepts the word. They are visible the following cycle.
- locked rises on the same edge as the LOCK_COUNT-th match.
- BCID tracking:
  - The BCID counter is 0 whenever the word's state is 17'h0AAAA. Otherwise it is the previous value + 1. It never exceeds 3563.
  - bcid_valid rises on the first accepted word whose state is 17'h0AAAA while in VERIFY or LOCKED.
  - bcid_valid clears on leaving LOCKED, or on re-seed from VERIFY.
- clear_err has priority over an increment in the same cycle: err_count=0 and the new error is not counted. err still pulses.
- Reset asserted mid-operation returns everything to the reset values on the next edge, regardless of enable.

Test Plan:
1. Reset, then feed a clean generator stream from seed 0x0AAAA with din_valid=1 every cycle. Expect: SEED after word 1, locked=1 after word 10 (2 + LOCK_COUNT). bcid_valid=1 at the seed-state word; bcid counts 0..3563 and wraps to 0 with no err across the 0x0A96E -> 0x0AAAA boundary.
2. While locked, flip bit 5 of one word. Expect: exactly one err pulse, err_count=1, locked stays 1, the next clean word matches, bcid continues incrementing.
3. While locked, corrupt 4 consecutive words. Expect: err pulses 4x, err_count=4, locked=0 and bcid_valid=0 after the 4th. The clean stream that follows relocks after 2+8 words.
4. Toggle din_valid in a random pattern (e.g. 1,0,0,1,0,1) with a clean stream. Expect: lock and bcid progression identical to the gap-free case, counted in accepted words; no err.
5. Force err_count to all-ones via injected errors at ERRCNT_WIDTH=4. Expect: saturation at 15. Then assert clear_err in the same cycle as an error. Expect: err_count=0, err=1.
6. Assert reset while locked. Expect: next cycle locked=0, bcid=0, bcid_valid=0, err_count=0. Start a feed mid-sequence (state BCID 1000). Expect: lock after 10 words, bcid_valid only after the wrap to BCID 0.
